axi_mem_responder: RTL and testbench



---
 rtl/axi_pkg.sv | 31 +++
 rtl/axi_burst_addr.sv | 31 +++
 rtl/axi_mem_responder.sv | 268 ++++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI memory responder and its helpers.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] SNOOP_MAKEINVALID = 4'b1101;

  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned BEAT_BYTES = 8;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_BURST = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_DATA  = 2'd1,
    W_SNOOP = 2'd2,
    W_RESP  = 2'd3
  } wr_state_t;

endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address for FIXED/INCR/WRAP bursts of 8-byte beats; flags illegal wrap lengths.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr_c,
  output logic                  wrap_err_c
);

  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  // (len+1)*8-1 equals (len<<3)|7 when len+1 is a power of two
  always_comb begin
    incr_addr   = addr + ADDR_WIDTH'(BEAT_BYTES);
    wrap_mask   = (ADDR_WIDTH'(len) << 3) | ADDR_WIDTH'(BEAT_BYTES - 1);
    wrap_err_c  = (burst == 2'(WRAP)) &&
                  !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    next_addr_c = incr_addr;
    if (burst == 2'(FIXED)) begin
      next_addr_c = addr;
    end else if ((burst == 2'(WRAP)) && !wrap_err_c) begin
      next_addr_c = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: latency-delayed read bursts, strobed write bursts,
// and one MakeInvalid snoop on AC after each write burst.
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter int unsigned          ID_WIDTH     = 13,
  parameter int unsigned          ADDR_WIDTH   = 64,
  parameter int unsigned          DATA_WIDTH   = 64,
  parameter int unsigned          STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned          MEM_WORDS    = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned          READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic                  s_axi_acvalid,
  output logic [ADDR_WIDTH-1:0] s_axi_acaddr,
  output logic [3:0]            s_axi_acsnoop,
  input  logic                  s_axi_acready
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic unused_sideband;
  assign unused_sideband = ^{s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                             s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot};

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 3) < ADDR_WIDTH'(MEM_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

  // ---------------- read engine ----------------
  rd_state_t             rd_state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            rd_len;
  logic [7:0]            rd_beat;
  logic [1:0]            rd_burst;
  logic [3:0]            rd_cnt;
  logic [ADDR_WIDTH-1:0] rd_next_c;
  logic                  rd_wrap_err_c;
  logic [ADDR_WIDTH-1:0] rd_fetch_c;
  logic                  rd_fetch_last_c;
  logic                  rd_ok_c;

  axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr (
    .addr        (rd_addr),
    .len         (rd_len),
    .burst       (rd_burst),
    .next_addr_c (rd_next_c),
    .wrap_err_c  (rd_wrap_err_c)
  );

  // In R_BURST the next beat is fetched at the handshake edge, so look one address ahead
  always_comb begin
    rd_fetch_c      = (rd_state == R_BURST) ? rd_next_c : rd_addr;
    rd_fetch_last_c = (((rd_state == R_BURST) ? (rd_beat + 8'd1) : rd_beat) == rd_len);
    rd_ok_c         = in_range(rd_fetch_c);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state      <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rid     <= '0;
      s_axi_rresp   <= RESP_OKAY;
      rd_addr       <= '0;
      rd_len        <= '0;
      rd_beat       <= '0;
      rd_burst      <= '0;
      rd_cnt        <= '0;
    end else begin
      unique case (rd_state)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            s_axi_rid     <= s_axi_arid;
            rd_addr       <= s_axi_araddr;
            rd_len        <= s_axi_arlen;
            rd_burst      <= s_axi_arburst;
            rd_beat       <= '0;
            rd_cnt        <= 4'(READ_LATENCY);
            s_axi_arready <= 1'b0;
            rd_state      <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rd_cnt == 4'd0) begin
            s_axi_rdata  <= rd_ok_c ? mem[word_idx(rd_fetch_c)] : '0;
            s_axi_rresp  <= (rd_ok_c && !rd_wrap_err_c) ? RESP_OKAY : RESP_SLVERR;
            s_axi_rlast  <= rd_fetch_last_c;
            s_axi_rvalid <= 1'b1;
            rd_state     <= R_BURST;
          end else begin
            rd_cnt <= rd_cnt - 4'd1;
          end
        end
        R_BURST: begin
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              rd_state      <= R_IDLE;
            end else begin
              rd_addr     <= rd_next_c;
              rd_beat     <= rd_beat + 8'd1;
              s_axi_rdata <= rd_ok_c ? mem[word_idx(rd_fetch_c)] : '0;
              s_axi_rresp <= (rd_ok_c && !rd_wrap_err_c) ? RESP_OKAY : RESP_SLVERR;
              s_axi_rlast <= rd_fetch_last_c;
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- write engine ----------------
  wr_state_t             wr_state;
  logic [ID_WIDTH-1:0]   wr_id;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] wr_line;
  logic [7:0]            wr_len;
  logic [7:0]            wr_beat;
  logic [1:0]            wr_burst;
  logic                  wr_err;
  logic [ADDR_WIDTH-1:0] wr_next_c;
  logic                  wr_wrap_err_c;
  logic                  wr_beat_err_c;
  logic                  mem_we_c;

  axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr (
    .addr        (wr_addr),
    .len         (wr_len),
    .burst       (wr_burst),
    .next_addr_c (wr_next_c),
    .wrap_err_c  (wr_wrap_err_c)
  );

  always_comb begin
    wr_beat_err_c = !in_range(wr_addr) || (s_axi_wlast != (wr_beat == wr_len));
    mem_we_c      = (wr_state == W_DATA) && s_axi_wvalid && in_range(wr_addr);
  end

  // Array itself is never reset; writes are gated by the reset-cleared FSM
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
        if (s_axi_wstrb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state      <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_acvalid <= 1'b0;
      s_axi_acaddr  <= '0;
      s_axi_acsnoop <= '0;
      wr_id         <= '0;
      wr_addr       <= '0;
      wr_line       <= '0;
      wr_len        <= '0;
      wr_beat       <= '0;
      wr_burst      <= '0;
      wr_err        <= 1'b0;
    end else begin
      unique case (wr_state)
        W_IDLE: begin
          if (s_axi_awvalid) begin
            wr_id         <= s_axi_awid;
            wr_addr       <= s_axi_awaddr;
            wr_line       <= s_axi_awaddr & ~ADDR_WIDTH'(LINE_BYTES - 1);
            wr_len        <= s_axi_awlen;
            wr_burst      <= s_axi_awburst;
            wr_beat       <= '0;
            wr_err        <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            wr_state      <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi_wvalid) begin
            if (wr_beat == wr_len) begin
              wr_err        <= wr_err | wr_beat_err_c | wr_wrap_err_c;
              s_axi_wready  <= 1'b0;
              s_axi_acvalid <= 1'b1;
              s_axi_acaddr  <= wr_line;
              s_axi_acsnoop <= SNOOP_MAKEINVALID;
              wr_state      <= W_SNOOP;
            end else begin
              wr_err  <= wr_err | wr_beat_err_c;
              wr_addr <= wr_next_c;
              wr_beat <= wr_beat + 8'd1;
            end
          end
        end
        W_SNOOP: begin
          if (s_axi_acready) begin
            s_axi_acvalid <= 1'b0;
            s_axi_bvalid  <= 1'b1;
            s_axi_bid     <= wr_id;
            s_axi_bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            wr_state      <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            wr_state      <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed, table-driven bench for axi_mem_responder.
module tb_axi_mem_responder;

  localparam int unsigned ID_W  = 13;
  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 64;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned WORDS = 4096;
  localparam int unsigned LAT   = 2;
  localparam int          TMO   = 100;

  localparam logic [1:0] B_FIXED = 2'd0;
  localparam logic [1:0] B_INCR  = 2'd1;
  localparam logic [1:0] B_WRAP  = 2'd2;

  localparam logic [63:0] D0 = 64'hC0DE_0000_0000_0100;
  localparam logic [63:0] D1 = 64'hC0DE_1111_0000_0108;
  localparam logic [63:0] D2 = 64'hC0DE_2222_0000_0110;
  localparam logic [63:0] D3 = 64'hC0DE_3333_0000_0118;
  localparam logic [63:0] DB = 64'hDEADBEEF_0BADF00D;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [ID_W-1:0] arid = '0;
  logic [AW-1:0]   araddr = '0;
  logic [7:0]      arlen = '0;
  logic [1:0]      arburst = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid;
  logic            rready = 1'b0;
  logic [ID_W-1:0] awid = '0;
  logic [AW-1:0]   awaddr = '0;
  logic [7:0]      awlen = '0;
  logic [1:0]      awburst = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [DW-1:0]   wdata = '0;
  logic [SW-1:0]   wstrb = '0;
  logic            wlast = 1'b0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b0;
  logic            acvalid;
  logic [AW-1:0]   acaddr;
  logic [3:0]      acsnoop;
  logic            acready = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_mem_responder #(
    .ID_WIDTH(ID_W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW),
    .MEM_WORDS(WORDS), .BASE_ADDR(64'h0), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(3'd3),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(3'd3),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_acvalid(acvalid), .s_axi_acaddr(acaddr), .s_axi_acsnoop(acsnoop),
    .s_axi_acready(acready)
  );

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [63:0]      addr;
    logic [7:0]       len;
    logic [1:0]       burst;
    logic [1:0]       resp;
    logic             dchk;
    logic [3:0][63:0] d;
  } rd_vec_t;

  function automatic rd_vec_t mk(input logic [ID_W-1:0] id, input logic [63:0] addr,
                                 input logic [7:0] len, input logic [1:0] burst,
                                 input logic [1:0] resp, input logic dchk,
                                 input logic [63:0] d0, input logic [63:0] d1,
                                 input logic [63:0] d2, input logic [63:0] d3);
    rd_vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.burst = burst; v.resp = resp; v.dchk = dchk;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0: return arready;
      1: return rvalid;
      2: return awready;
      3: return wready;
      4: return acvalid;
      5: return bvalid;
      default: return 1'b0;
    endcase
  endfunction

  // All tasks are entered and left just after a falling edge
  task automatic wait_for(input int w, input string name, output int n);
    n = 0;
    while (!sig(w) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!sig(w)) begin
      checks++;
      errors++;
      $display("FAIL timeout %s: got 0 cycles-left expected handshake within %0d", name, TMO);
    end
  endtask

  task automatic do_ar(input logic [ID_W-1:0] id, input logic [63:0] addr,
                       input logic [7:0] len, input logic [1:0] burst);
    int n;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    wait_for(0, "arready", n);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic get_beat(input string name, input logic [63:0] d, input logic dchk,
                          input logic [1:0] resp, input logic last,
                          input logic [ID_W-1:0] id, output int n);
    rready = 1'b1;
    wait_for(1, name, n);
    if (dchk) chk({name, " rdata"}, rdata, d);
    chk({name, " rresp"}, 64'(rresp), 64'(resp));
    chk({name, " rlast"}, 64'(rlast), 64'(last));
    chk({name, " rid"}, 64'(rid), 64'(id));
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic do_aw(input logic [ID_W-1:0] id, input logic [63:0] addr,
                       input logic [7:0] len, input logic [1:0] burst);
    int n;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    wait_for(2, "awready", n);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] d, input logic [7:0] strb, input logic last);
    int n;
    wdata = d; wstrb = strb; wlast = last; wvalid = 1'b1;
    wait_for(3, "wready", n);
    @(negedge clk);
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic snoop_b(input string name, input logic [63:0] line,
                         input logic [ID_W-1:0] id, input logic [1:0] resp);
    int n;
    wait_for(4, {name, " acvalid"}, n);
    chk({name, " acaddr"}, acaddr, line);
    chk({name, " acsnoop"}, 64'(acsnoop), 64'hD);
    acready = 1'b1;
    @(negedge clk);
    acready = 1'b0;
    chk({name, " bvalid next cycle"}, 64'(bvalid), 64'd1);
    wait_for(5, {name, " bvalid"}, n);
    chk({name, " bid"}, 64'(bid), 64'(id));
    chk({name, " bresp"}, 64'(bresp), 64'(resp));
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk({name, " awready back"}, 64'(awready), 64'd1);
  endtask

  rd_vec_t vec [7];

  initial begin
    int n;
    vec[0] = mk(13'd5, 64'h80,   8'd0, B_INCR,  2'b00, 1'b1, DB, 64'h0, 64'h0, 64'h0);
    vec[1] = mk(13'd3, 64'h118,  8'd3, B_WRAP,  2'b00, 1'b1, D3, D0, D1, D2);
    vec[2] = mk(13'd7, 64'h100,  8'd3, B_INCR,  2'b00, 1'b1, D0, D1, D2, D3);
    vec[3] = mk(13'd1, 64'h108,  8'd2, B_FIXED, 2'b00, 1'b1, D1, D1, D1, 64'h0);
    vec[4] = mk(13'd2, 64'h10A,  8'd0, B_INCR,  2'b00, 1'b1, D1, 64'h0, 64'h0, 64'h0);
    vec[5] = mk(13'd4, 64'h8000, 8'd0, B_INCR,  2'b10, 1'b1, 64'h0, 64'h0, 64'h0, 64'h0);
    vec[6] = mk(13'd6, 64'h100,  8'd2, B_WRAP,  2'b10, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0);

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst arready", 64'(arready), 64'd1);
    chk("rst awready", 64'(awready), 64'd1);
    chk("rst valids", {59'd0, rvalid, wready, bvalid, acvalid, rlast}, 64'd0);
    chk("rst rdata", rdata, 64'd0);
    chk("rst ids/resps", {34'd0, rid, bid, rresp, bresp}, 64'd0);
    chk("rst acaddr", acaddr, 64'd0);
    chk("rst acsnoop", 64'(acsnoop), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Preload through the write port
    do_aw(13'h1A, 64'h100, 8'd3, B_INCR);
    do_w(D0, 8'hFF, 1'b0);
    do_w(D1, 8'hFF, 1'b0);
    do_w(D2, 8'hFF, 1'b0);
    do_w(D3, 8'hFF, 1'b1);
    snoop_b("wr preload", 64'h100, 13'h1A, 2'b00);
    do_aw(13'd2, 64'h80, 8'd0, B_INCR);
    do_w(DB, 8'hFF, 1'b1);
    snoop_b("wr 0x80", 64'h80, 13'd2, 2'b00);

    // Table of read bursts: latency, no inter-beat bubble, data/resp/last/id
    for (int i = 0; i < 7; i++) begin
      do_ar(vec[i].id, vec[i].addr, vec[i].len, vec[i].burst);
      for (int b = 0; b <= int'(vec[i].len); b++) begin
        get_beat($sformatf("rd%0d.b%0d", i, b), vec[i].d[b], vec[i].dchk, vec[i].resp,
                 (b == int'(vec[i].len)), vec[i].id, n);
        if (b == 0) chk($sformatf("rd%0d latency", i), 64'(n), 64'(LAT + 1));
        else        chk($sformatf("rd%0d bubble", i), 64'(n), 64'd0);
      end
      chk($sformatf("rd%0d rvalid drop", i), 64'(rvalid), 64'd0);
    end

    // Strobed write: prefill, then partial write, then read back
    do_aw(13'd8, 64'h200, 8'd1, B_INCR);
    do_w(64'h5555_5555_5555_5555, 8'hFF, 1'b0);
    do_w(64'h6666_6666_6666_6666, 8'hFF, 1'b1);
    snoop_b("wr prefill", 64'h200, 13'd8, 2'b00);
    do_aw(13'd9, 64'h200, 8'd1, B_INCR);
    do_w(64'h1111_1111_1111_1111, 8'h0F, 1'b0);
    do_w(64'h2222_2222_2222_2222, 8'hFF, 1'b1);
    snoop_b("wr strb", 64'h200, 13'd9, 2'b00);
    do_ar(13'd10, 64'h200, 8'd1, B_INCR);
    get_beat("strb rb0", 64'h5555_5555_1111_1111, 1'b1, 2'b00, 1'b0, 13'd10, n);
    get_beat("strb rb1", 64'h2222_2222_2222_2222, 1'b1, 2'b00, 1'b1, 13'd10, n);

    // rready stall mid-burst
    do_ar(13'd11, 64'h100, 8'd3, B_INCR);
    get_beat("stall b0", D0, 1'b1, 2'b00, 1'b0, 13'd11, n);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall hold%0d", c), {rdata[62:0], rvalid}, {D1[62:0], 1'b1});
      chk($sformatf("stall rlast%0d", c), 64'(rlast), 64'd0);
      @(negedge clk);
    end
    get_beat("stall b1", D1, 1'b1, 2'b00, 1'b0, 13'd11, n);
    get_beat("stall b2", D2, 1'b1, 2'b00, 1'b0, 13'd11, n);
    get_beat("stall b3", D3, 1'b1, 2'b00, 1'b1, 13'd11, n);

    // Write error cases
    do_aw(13'd12, 64'h8000, 8'd0, B_INCR);
    do_w(64'h0, 8'hFF, 1'b1);
    snoop_b("wr oob", 64'h8000, 13'd12, 2'b10);
    do_aw(13'd13, 64'h318, 8'd1, B_INCR);
    do_w(64'h0, 8'hFF, 1'b1);
    do_w(64'h0, 8'hFF, 1'b0);
    snoop_b("wr wlast", 64'h300, 13'd13, 2'b10);

    // Reset in the middle of a write data phase
    do_aw(13'd14, 64'h400, 8'd3, B_INCR);
    do_w(64'h7777_7777_7777_7777, 8'hFF, 1'b0);
    chk("pre-rst wready", 64'(wready), 64'd1);
    reset = 1'b0;
    #1;
    chk("midrst wready", 64'(wready), 64'd0);
    chk("midrst ac/b", {62'd0, acvalid, bvalid}, 64'd0);
    chk("midrst awready", 64'(awready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_aw(13'd15, 64'h408, 8'd0, B_INCR);
    do_w(64'h8888_8888_8888_8888, 8'hFF, 1'b1);
    snoop_b("wr post-rst", 64'h400, 13'd15, 2'b00);
    do_ar(13'd16, 64'h400, 8'd1, B_INCR);
    get_beat("post-rst rb0", 64'h7777_7777_7777_7777, 1'b1, 2'b00, 1'b0, 13'd16, n);
    get_beat("post-rst rb1", 64'h8888_8888_8888_8888, 1'b1, 2'b00, 1'b1, 13'd16, n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
